// File: rtl/fdc_image_server_if.sv
// Byte-wide memory bus between the sector server and the external image
// memory (SRAM/SDRAM arbiter port).
//
//   mem_addr   byte address, valid while mem_rd or mem_wr is high
//   mem_rd     read request, held until mem_ack
//   mem_wr     write request, held until mem_ack
//   mem_wdata  write data, held with mem_wr
//   mem_rdata  read data, valid in the mem_ack cycle
//   mem_ack    one-cycle completion pulse
//
// master: the sector server. slave: the memory / arbiter.
interface fdc_image_server_if #(
    parameter int ADDR_WIDTH = 21
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [7:0]            mem_wdata;
    logic [7:0]            mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/fdc_image_server.sv
// Sector server behind the WD1770 emulation's dsr/dcr port. Decodes sector
// read/write commands, maps side/track/sector onto a linear byte address in
// an MGT disk image and moves one 512-byte sector between the image memory
// and the FDC FIFOs, then completes the ack / ack-of-ack handshake.
//
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   dsr           command word: [7:0] sect, [14:8] trk, [15] side,
//                 [23] drst, [24] rd0, [25] rd1, [26] wr0, [27] wr1
//   dcr           status: [4] ack, [3] err, all other bits 0
//   dd0in         byte to the FDC input FIFO
//   dd0inclk      one-cycle write strobe for dd0in
//   dd0out        head of the FDC output FIFO (show-ahead)
//   dd0outclk     one-cycle pop strobe for the FDC output FIFO
//   img_present   per-drive image-mounted flags
//   mem           memory bus (master side)
//   busy          high whenever the server is not idle
module fdc_image_server #(
    parameter int                    SPT         = 10,
    parameter int                    TRACKS      = 80,
    parameter int                    SIDES       = 2,
    parameter int                    ADDR_WIDTH  = 21,
    parameter logic [ADDR_WIDTH-1:0] DRIVE1_BASE = 21'h100000
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [31:0]               dsr,
    output logic [31:0]               dcr,
    output logic [7:0]                dd0in,
    output logic                      dd0inclk,
    input  logic [7:0]                dd0out,
    output logic                      dd0outclk,
    input  logic [1:0]                img_present,
    fdc_image_server_if.master        mem,
    output logic                      busy
);

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        RD_REQ,
        RD_WAIT,
        RD_PUSH,
        WR_REQ,
        WR_WAIT,
        ACK,
        DRST_LO
    } state_t;

    state_t                state;
    logic                  is_wr;
    logic                  drive;
    logic                  side_r;
    logic [6:0]            trk_r;
    logic [7:0]            sect_r;
    logic [8:0]            idx;
    logic [ADDR_WIDTH-1:0] sect_base;
    logic                  ack_r;
    logic                  err_r;

    // Command decode, priority rd0 > rd1 > wr0 > wr1.
    logic cmd_valid;
    logic cmd_wr;
    logic cmd_drive;

    always_comb begin
        // NOTE: defaults first so every path assigns; an incomplete if-chain
        // would otherwise infer a latch.
        cmd_valid = |dsr[27:24];
        cmd_wr    = 1'b0;
        cmd_drive = 1'b0;
        if (!dsr[24]) begin
            if (dsr[25]) begin
                cmd_drive = 1'b1;
            end else if (dsr[26]) begin
                cmd_wr = 1'b1;
            end else if (dsr[27]) begin
                cmd_wr    = 1'b1;
                cmd_drive = 1'b1;
            end
        end
    end

    // Geometry check and linear sector number from the latched fields.
    // Worst case (79*2+1)*10+9 = 1599 fits the 11-bit arithmetic.
    logic [10:0] lba;
    logic        bad_cmd;

    assign lba = (11'(trk_r) * 11'(SIDES) + 11'(side_r)) * 11'(SPT)
               + 11'(sect_r) - 11'd1;

    assign bad_cmd = (sect_r == 8'd0)
                  || (32'(sect_r) > SPT)
                  || (32'(trk_r) >= TRACKS)
                  || (32'(side_r) >= SIDES)
                  || !img_present[drive];

    assign dcr = {27'd0, ack_r, err_r, 3'd0};

    // The pop has to land in the mem_ack cycle itself so that the next
    // WR_REQ samples the new FIFO head; a registered strobe would be one
    // cycle late and write the same byte twice. Gated by rstn so a reset
    // cycle never pops.
    assign dd0outclk = rstn && (state == WR_WAIT) && mem.mem_ack;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register
        // updates from pre-edge values, independent of statement order.
        if (!rstn) begin
            state         <= IDLE;
            is_wr         <= 1'b0;
            drive         <= 1'b0;
            side_r        <= 1'b0;
            trk_r         <= '0;
            sect_r        <= '0;
            idx           <= '0;
            sect_base     <= '0;
            ack_r         <= 1'b0;
            err_r         <= 1'b0;
            dd0in         <= '0;
            dd0inclk      <= 1'b0;
            busy          <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_rd    <= 1'b0;
            mem.mem_wr    <= 1'b0;
            mem.mem_wdata <= '0;
        end else begin
            dd0inclk <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        is_wr  <= cmd_wr;
                        drive  <= cmd_drive;
                        side_r <= dsr[15];
                        trk_r  <= dsr[14:8];
                        sect_r <= dsr[7:0];
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end

                CHECK: begin
                    idx <= '0;
                    if (bad_cmd) begin
                        ack_r <= 1'b1;
                        err_r <= 1'b1;
                        state <= ACK;
                    end else begin
                        sect_base <= (drive ? DRIVE1_BASE : '0)
                                   + ADDR_WIDTH'({lba, 9'b0});
                        state     <= is_wr ? WR_REQ : RD_REQ;
                    end
                end

                RD_REQ: begin
                    mem.mem_addr <= sect_base + ADDR_WIDTH'(idx);
                    mem.mem_rd   <= 1'b1;
                    state        <= RD_WAIT;
                end

                // The strobe is raised here so that it is high exactly
                // during RD_PUSH, with dd0in holding the captured byte.
                RD_WAIT: begin
                    if (mem.mem_ack) begin
                        dd0in      <= mem.mem_rdata;
                        dd0inclk   <= 1'b1;
                        mem.mem_rd <= 1'b0;
                        state      <= RD_PUSH;
                    end
                end

                RD_PUSH: begin
                    if (idx == 9'd511) begin
                        ack_r <= 1'b1;
                        state <= ACK;
                    end else begin
                        idx   <= idx + 9'd1;
                        state <= RD_REQ;
                    end
                end

                WR_REQ: begin
                    mem.mem_addr  <= sect_base + ADDR_WIDTH'(idx);
                    mem.mem_wdata <= dd0out;
                    mem.mem_wr    <= 1'b1;
                    state         <= WR_WAIT;
                end

                WR_WAIT: begin
                    if (mem.mem_ack) begin
                        mem.mem_wr <= 1'b0;
                        if (idx == 9'd511) begin
                            ack_r <= 1'b1;
                            state <= ACK;
                        end else begin
                            idx   <= idx + 9'd1;
                            state <= WR_REQ;
                        end
                    end
                end

                ACK: begin
                    if (dsr[23]) begin
                        ack_r <= 1'b0;
                        err_r <= 1'b0;
                        state <= DRST_LO;
                    end
                end

                // Command bits may still be set here; they are only looked
                // at again once drst has dropped and we are back in IDLE.
                DRST_LO: begin
                    if (!dsr[23]) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdc_image_server.sv
// Directed bench for fdc_image_server: memory responder with programmable
// ack latency (memory[a] = a[7:0]), show-ahead FIFO preloaded 0xA5, 0xA6, ...
module tb_fdc_image_server;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] dsr = 32'h0;
    logic [1:0]  img = 2'b00;
    wire  [31:0] dcr;
    wire  [7:0]  dd0in;
    wire         dd0inclk;
    wire  [7:0]  dd0out;
    wire         dd0outclk;
    wire         busy;

    fdc_image_server_if #(.ADDR_WIDTH(21)) m ();

    fdc_image_server dut (
        .clk         (clk),
        .rstn        (rstn),
        .dsr         (dsr),
        .dcr         (dcr),
        .dd0in       (dd0in),
        .dd0inclk    (dd0inclk),
        .dd0out      (dd0out),
        .dd0outclk   (dd0outclk),
        .img_present (img),
        .mem         (m.slave),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // FIFO / strobe monitor. Every read command starts on a 512-byte
    // boundary and memory[a] = a[7:0], so pushed byte n carries n[7:0].
    int          inclk_total  = 0;
    int          in_bad       = 0;
    int          outclk_total = 0;
    int          strobe_bad   = 0;
    int          pop_ptr      = 0;
    logic        prev_in      = 1'b0;
    logic        prev_out     = 1'b0;

    assign dd0out = 8'hA5 + pop_ptr[7:0];

    always @(posedge clk) begin
        if (dd0inclk === 1'b1) begin
            if (dd0in !== inclk_total[7:0]) in_bad++;
            inclk_total++;
        end
        if (dd0outclk === 1'b1) begin
            outclk_total++;
            pop_ptr <= pop_ptr + 1;
        end
        if ((dd0inclk === 1'b1 && prev_in) || (dd0outclk === 1'b1 && prev_out)) strobe_bad++;
        prev_in  <= (dd0inclk === 1'b1);
        prev_out <= (dd0outclk === 1'b1);
    end

    // Memory responder: captures a request, acks ack_delay cycles later.
    int          ack_delay    = 0;
    logic [20:0] exp_wr_base  = 21'h0;
    int          rd_req_total = 0;
    int          wr_total     = 0;
    int          wr_bad       = 0;
    logic [20:0] first_addr   = 21'h0;
    logic [20:0] last_addr    = 21'h0;
    bit          pend         = 1'b0;
    int          cnt          = 0;
    logic [20:0] p_addr;
    logic        p_wr;
    logic [7:0]  p_data;

    always @(posedge clk) begin
        m.mem_ack <= 1'b0;
        if (!pend && m.mem_ack !== 1'b1 && (m.mem_rd === 1'b1 || m.mem_wr === 1'b1)) begin
            pend   = 1'b1;
            cnt    = ack_delay;
            p_addr = m.mem_addr;
            p_wr   = (m.mem_wr === 1'b1);
            p_data = m.mem_wdata;
            if (p_wr) begin
                if (p_addr !== exp_wr_base + 21'(wr_total) || p_data !== 8'hA5 + wr_total[7:0]) wr_bad++;
                wr_total++;
            end else begin
                if (rd_req_total % 512 == 0) first_addr = p_addr;
                last_addr = p_addr;
                rd_req_total++;
            end
        end
        if (pend) begin
            if (cnt == 0) begin
                m.mem_ack   <= 1'b1;
                m.mem_rdata <= p_addr[7:0];
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end
    end

    // Issue a command, wait for ack, then run the drst handshake with the
    // stale command bits still present.
    task automatic run_cmd(input string tag, input logic [31:0] cmd,
                           input logic [31:0] exp_dcr, input int limit);
        int n;
        @(negedge clk);
        dsr = cmd;
        @(negedge clk);
        check({tag, "_busy"}, busy, 1);
        n = 0;
        while (dcr[4] !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_dcr"}, dcr, exp_dcr);
        dsr = dsr | 32'h0080_0000;
        @(negedge clk);
        check({tag, "_dcr_clr"}, dcr, 0);
        @(negedge clk);
        check({tag, "_busy_hold"}, busy, 1);
        dsr = 32'h0;
        @(negedge clk);
        check({tag, "_idle"}, busy, 0);
    endtask

    int s_in, s_rd, s_wr, s_out, n;
    logic [31:0] err_cmd [4];
    logic [1:0]  err_img [4];

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dcr", dcr, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_rd", m.mem_rd, 0);
        check("rst_mem_wr", m.mem_wr, 0);
        check("rst_inclk", dd0inclk, 0);
        rstn = 1'b1;

        // 1: rd0, side0 trk0 sect1 -> lba 0, bytes 0x00..0xFF twice
        img = 2'b01;
        s_in = inclk_total; s_rd = rd_req_total;
        run_cmd("t1", 32'h0100_0001, 32'h10, 5000);
        check("t1_reqs", rd_req_total - s_rd, 512);
        check("t1_first", first_addr, 32'h0000_0000);
        check("t1_last", last_addr, 32'h0000_01FF);
        check("t1_pushes", inclk_total - s_in, 512);
        check("t1_data_bad", in_bad, 0);

        // 2: rd1, side1 trk5 sect3 -> lba (5*2+1)*10+2 = 112 -> 0x10E000
        img = 2'b11;
        s_in = inclk_total; s_rd = rd_req_total;
        run_cmd("t2", 32'h0200_8503, 32'h10, 5000);
        check("t2_first", first_addr, 32'h0010_E000);
        check("t2_last", last_addr, 32'h0010_E1FF);
        check("t2_pushes", inclk_total - s_in, 512);

        // 3: wr0, side1 trk79 sect10 -> lba 1599 -> 0x0C7E00 (last sector of image)
        exp_wr_base = 21'h0C7E00;
        s_rd = rd_req_total; s_out = outclk_total;
        run_cmd("t3", 32'h0400_CF0A, 32'h10, 5000);
        check("t3_writes", wr_total, 512);
        check("t3_wr_bad", wr_bad, 0);
        check("t3_pops", outclk_total - s_out, 512);
        check("t3_no_rd", rd_req_total - s_rd, 0);

        // 4: geometry / mount errors -> dcr 0x18 within 3 cycles, no access
        err_cmd[0] = 32'h0100_0000; err_img[0] = 2'b11;  // sect 0
        err_cmd[1] = 32'h0100_000B; err_img[1] = 2'b11;  // sect 11
        err_cmd[2] = 32'h0100_5001; err_img[2] = 2'b11;  // trk 80
        err_cmd[3] = 32'h0100_0001; err_img[3] = 2'b10;  // drive 0 not mounted
        s_in = inclk_total; s_rd = rd_req_total;
        for (int i = 0; i < 4; i++) begin
            img = err_img[i];
            run_cmd($sformatf("t4_%0d", i), err_cmd[i], 32'h18, 2);
        end
        check("t4_no_rd", rd_req_total - s_rd, 0);
        check("t4_no_push", inclk_total - s_in, 0);

        // 5: rd0 and wr1 together -> read wins
        img = 2'b11;
        s_rd = rd_req_total; s_wr = wr_total; s_out = outclk_total;
        run_cmd("t5", 32'h0900_0001, 32'h10, 5000);
        check("t5_reads", rd_req_total - s_rd, 512);
        check("t5_no_wr", wr_total - s_wr, 0);
        check("t5_no_pop", outclk_total - s_out, 0);
        check("strobe_back_to_back", strobe_bad, 0);

        // 6: reset after 100 bytes with a delayed ack in flight
        ack_delay = 4;
        img = 2'b01;
        s_in = inclk_total;
        @(negedge clk);
        dsr = 32'h0100_0001;
        n = 0;
        while (inclk_total - s_in < 100 && n < 5000) begin @(negedge clk); n++; end
        check("t6_progress", (inclk_total - s_in >= 100), 1);
        n = 0;
        while (m.mem_rd !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("t6_req_pending", m.mem_rd, 1);
        @(negedge clk);
        rstn = 1'b0;
        dsr  = 32'h0;
        @(negedge clk);
        check("t6_mem_rd", m.mem_rd, 0);
        check("t6_inclk", dd0inclk, 0);
        check("t6_dcr", dcr, 0);
        check("t6_busy", busy, 0);
        s_in = inclk_total;
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_late_ack_push", inclk_total - s_in, 0);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_mem_rd", m.mem_rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
